// File: rtl/flow_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// flow_ctrl_pkg
//
// Shared definitions for the rooth core pipeline flow controller.
//
// Contents:
//   FLOW_WIDTH    width of every per-stage flow code
//   flow_e        flow codes driven to the PC and inter-stage registers
//                 (WORK = advance, STOP = hold, REFRESH = load a bubble)
//   fc_state_e    flow controller sequencing states
//   CNT_WIDTH     width of the interrupt drain counter (DRAIN_CYCLES <= 15)
//   flow_set_t    the four flow codes bundled as one value
//   make_flows()  builds a flow_set_t from four codes
// ----------------------------------------------------------------------------
package flow_ctrl_pkg;

    localparam int FLOW_WIDTH = 2;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [FLOW_WIDTH-1:0] {
        FLOW_WORK    = 2'b00,
        FLOW_STOP    = 2'b01,
        FLOW_REFRESH = 2'b10
    } flow_e;

    typedef enum logic [1:0] {
        FC_RUN       = 2'b00,
        FC_DIV_WAIT  = 2'b01,
        FC_IRQ_DRAIN = 2'b10
    } fc_state_e;

    typedef struct packed {
        flow_e pc;
        flow_e de;
        flow_e ex;
        flow_e mem;
    } flow_set_t;

    function automatic flow_set_t make_flows(input flow_e pc, input flow_e de,
                                             input flow_e ex, input flow_e mem);
        flow_set_t f;
        f.pc  = pc;
        f.de  = de;
        f.ex  = ex;
        f.mem = mem;
        return f;
    endfunction

endpackage

// File: rtl/flow_ctrl.sv
// ----------------------------------------------------------------------------
// flow_ctrl
//
// Central pipeline flow controller. Produces the flow code (work / stop /
// refresh) for the PC and the IF/DE, DE/EX and EX/MEM registers, resolving
// load-use, jump, memory-stall, divide and interrupt events by fixed priority,
// and sequencing the divide-wait and interrupt-drain episodes.
//
// Parameters:
//   DRAIN_CYCLES  cycles EX/MEM keep retiring before interrupt entry (1..15)
//
// Ports:
//   clk           core clock
//   rst_n         asynchronous active-low reset
//   load_use_i    DE instruction sources rd of a load currently in EX
//   jump_i        EX resolved a taken branch/jump
//   mem_stall_i   data memory not ready
//   div_start_i   EX holds a divide needing the multi-cycle divider
//   div_done_i    divider result valid this cycle
//   irq_i         level interrupt request
//   flow_pc_o     flow code for the PC register
//   flow_de_o     flow code for IF/DE
//   flow_ex_o     flow code for DE/EX
//   flow_mem_o    flow code for EX/MEM
//   irq_ack_o     one-cycle pulse: PC loads the trap vector this cycle
//   stall_cnt_o   saturating count of cycles with flow_pc_o = STOP
// ----------------------------------------------------------------------------
module flow_ctrl
    import flow_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_use_i,
    input  logic                  jump_i,
    input  logic                  mem_stall_i,
    input  logic                  div_start_i,
    input  logic                  div_done_i,
    input  logic                  irq_i,
    output logic [FLOW_WIDTH-1:0] flow_pc_o,
    output logic [FLOW_WIDTH-1:0] flow_de_o,
    output logic [FLOW_WIDTH-1:0] flow_ex_o,
    output logic [FLOW_WIDTH-1:0] flow_mem_o,
    output logic                  irq_ack_o,
    output logic [31:0]           stall_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);

    fc_state_e            state;
    fc_state_e            state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 irq_pend;
    logic                 irq_pend_next;
    flow_set_t            flows;
    logic                 ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FC_RUN;
            cnt      <= '0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            irq_pend <= irq_pend_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        irq_pend_next = irq_pend;
        flows         = make_flows(FLOW_WORK, FLOW_WORK, FLOW_WORK, FLOW_WORK);
        ack           = 1'b0;

        case (state)
            FC_RUN: begin
                if (irq_i || irq_pend) begin
                    // Older instructions in EX/MEM keep retiring; the younger
                    // ones in DE/EX are squashed since they restart after the trap.
                    state_next = FC_IRQ_DRAIN;
                    cnt_next   = DRAIN_LOAD;
                    flows      = make_flows(FLOW_STOP, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK);
                end else if (mem_stall_i) begin
                    flows = make_flows(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP);
                end else if (jump_i) begin
                    // Jump beats load-use: the dependent DE instruction is flushed anyway.
                    flows = make_flows(FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK);
                end else if (div_start_i) begin
                    state_next = FC_DIV_WAIT;
                    flows      = make_flows(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH);
                end else if (load_use_i) begin
                    flows = make_flows(FLOW_STOP, FLOW_STOP, FLOW_REFRESH, FLOW_WORK);
                end
            end

            FC_DIV_WAIT: begin
                // MEM only sees bubbles here, so a memory stall has nothing to hold.
                if (irq_i) begin
                    irq_pend_next = 1'b1;
                end
                if (div_done_i) begin
                    state_next = FC_RUN;
                end else begin
                    flows = make_flows(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_REFRESH);
                end
            end

            FC_IRQ_DRAIN: begin
                if (mem_stall_i) begin
                    flows = make_flows(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_STOP);
                end else if (cnt == '0) begin
                    ack           = 1'b1;
                    irq_pend_next = 1'b0;
                    state_next    = FC_RUN;
                    flows         = make_flows(FLOW_WORK, FLOW_REFRESH, FLOW_REFRESH, FLOW_WORK);
                end else begin
                    cnt_next = cnt - 1'b1;
                    flows    = make_flows(FLOW_STOP, FLOW_STOP, FLOW_STOP, FLOW_WORK);
                end
            end

            default: begin
                state_next = FC_RUN;
            end
        endcase
    end

    // Outputs are forced to WORK during reset so the pipeline registers
    // see a benign code regardless of what the inputs are doing.
    always_comb begin
        flow_pc_o  = FLOW_WORK;
        flow_de_o  = FLOW_WORK;
        flow_ex_o  = FLOW_WORK;
        flow_mem_o = FLOW_WORK;
        irq_ack_o  = 1'b0;
        if (rst_n) begin
            flow_pc_o  = flows.pc;
            flow_de_o  = flows.de;
            flow_ex_o  = flows.ex;
            flow_mem_o = flows.mem;
            irq_ack_o  = ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if ((flow_pc_o == FLOW_STOP) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_flow_ctrl
//
// Self-checking bench for flow_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural model of the flow rules.
// ----------------------------------------------------------------------------
module tb_flow_ctrl;
    import flow_ctrl_pkg::*;

    localparam int DRAIN = 2;

    localparam logic [1:0] W = FLOW_WORK;
    localparam logic [1:0] S = FLOW_STOP;
    localparam logic [1:0] R = FLOW_REFRESH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_use = 1'b0;
    logic        jump = 1'b0;
    logic        mem_stall = 1'b0;
    logic        div_start = 1'b0;
    logic        div_done = 1'b0;
    logic        irq = 1'b0;
    logic [1:0]  flow_pc;
    logic [1:0]  flow_de;
    logic [1:0]  flow_ex;
    logic [1:0]  flow_mem;
    logic        irq_ack;
    logic [31:0] stall_cnt;
    logic [8:0]  obs;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: what the pipeline is "busy with" and how much
    // drain work remains before the trap vector is taken.
    bit          m_dividing;
    bit          m_draining;
    int          m_drain_left;
    bit          m_irq_owed;
    int unsigned m_stalls;

    flow_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_use_i  (load_use),
        .jump_i      (jump),
        .mem_stall_i (mem_stall),
        .div_start_i (div_start),
        .div_done_i  (div_done),
        .irq_i       (irq),
        .flow_pc_o   (flow_pc),
        .flow_de_o   (flow_de),
        .flow_ex_o   (flow_ex),
        .flow_mem_o  (flow_mem),
        .irq_ack_o   (irq_ack),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {flow_pc, flow_de, flow_ex, flow_mem, irq_ack};

    function automatic logic [8:0] fl(input logic [1:0] pc, input logic [1:0] de,
                                      input logic [1:0] ex, input logic [1:0] mem,
                                      input logic ack);
        return {pc, de, ex, mem, ack};
    endfunction

    // Inputs change mid-cycle; outputs are sampled 1ns later, well before
    // the next rising edge consumes them.
    task automatic drive(input logic lu, input logic j, input logic ms,
                         input logic ds, input logic dd, input logic ir);
        @(negedge clk);
        load_use  = lu;
        jump      = j;
        mem_stall = ms;
        div_start = ds;
        div_done  = dd;
        irq       = ir;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load_use = 0; jump = 0; mem_stall = 0; div_start = 0; div_done = 0; irq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        m_dividing = 0; m_draining = 0; m_drain_left = 0; m_irq_owed = 0; m_stalls = 0;
    endtask

    function automatic logic [8:0] model_expect();
        if (m_draining) begin
            if (mem_stall)          return fl(S, S, S, S, 0);
            if (m_drain_left == 0)  return fl(W, R, R, W, 1);
            return fl(S, S, S, W, 0);
        end
        if (m_dividing) begin
            if (div_done) return fl(W, W, W, W, 0);
            return fl(S, S, S, R, 0);
        end
        if (irq || m_irq_owed) return fl(S, R, R, W, 0);
        if (mem_stall)         return fl(S, S, S, S, 0);
        if (jump)              return fl(W, R, R, W, 0);
        if (div_start)         return fl(S, S, S, R, 0);
        if (load_use)          return fl(S, S, R, W, 0);
        return fl(W, W, W, W, 0);
    endfunction

    // Applies the effect of the current cycle's inputs at the coming edge.
    task automatic model_advance(input logic [8:0] e);
        if (e[8:7] == S && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        if (m_draining) begin
            if (!mem_stall) begin
                if (m_drain_left == 0) begin
                    m_draining = 0;
                    m_irq_owed = 0;
                end else begin
                    m_drain_left--;
                end
            end
        end else if (m_dividing) begin
            if (irq) m_irq_owed = 1;
            if (div_done) m_dividing = 0;
        end else if (irq || m_irq_owed) begin
            m_draining   = 1;
            m_drain_left = DRAIN - 1;
        end else if (!mem_stall && !jump && div_start) begin
            m_dividing = 1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load_use = 1; jump = 0; mem_stall = 1; div_start = 1; div_done = 0; irq = 1;
        #1;
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL reset_flows: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        do_reset();
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL reset_idle_run: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== fl(S, S, R, W, 0)) begin
            failures++;
            $display("[TB] FAIL load_use_bubble: got %h expected %h", obs, fl(S, S, R, W, 0));
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL load_use_resume: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            failures++;
            $display("[TB] FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_jump_over_load_use();
        do_reset();
        drive(1, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== fl(W, R, R, W, 0)) begin
            failures++;
            $display("[TB] FAIL jump_wins: got %h expected %h", obs, fl(W, R, R, W, 0));
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL jump_stall_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_divide();
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== fl(S, S, S, R, 0)) begin
            failures++;
            $display("[TB] FAIL div_start: got %h expected %h", obs, fl(S, S, S, R, 0));
        end
        for (int i = 0; i < 4; i++) begin
            // A memory stall in the middle of the wait must not change anything.
            drive(0, 0, (i == 2), 0, 0, 0);
            checks++;
            if (obs !== fl(S, S, S, R, 0)) begin
                failures++;
                $display("[TB] FAIL div_wait_%0d: got %h expected %h", i, obs, fl(S, S, S, R, 0));
            end
        end
        drive(0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL div_release: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL div_back_in_run: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
        checks++;
        if (stall_cnt !== 32'd5) begin
            failures++;
            $display("[TB] FAIL div_stall_cnt: got %0d expected 5", stall_cnt);
        end
    endtask

    task automatic test_irq();
        logic [8:0] exp_seq [6];
        do_reset();
        // Plain entry: sample, one drain cycle, then the ack cycle.
        exp_seq[0] = fl(S, R, R, W, 0);
        exp_seq[1] = fl(S, S, S, W, 0);
        exp_seq[2] = fl(W, R, R, W, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            checks++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL irq_seq_%0d: got %h expected %h", i, obs, exp_seq[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL irq_after_ack: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
        checks++;
        if (stall_cnt !== 32'd2) begin
            failures++;
            $display("[TB] FAIL irq_stall_cnt: got %0d expected 2", stall_cnt);
        end
        // Three memory-stall cycles at the point the ack would have fired.
        exp_seq[0] = fl(S, R, R, W, 0);
        exp_seq[1] = fl(S, S, S, W, 0);
        exp_seq[2] = fl(S, S, S, S, 0);
        exp_seq[3] = fl(S, S, S, S, 0);
        exp_seq[4] = fl(S, S, S, S, 0);
        exp_seq[5] = fl(W, R, R, W, 1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, (i >= 2 && i <= 4), 0, 0, 1);
            checks++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL irq_stalled_seq_%0d: got %h expected %h", i, obs, exp_seq[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 32'd7) begin
            failures++;
            $display("[TB] FAIL irq_stalled_stall_cnt: got %0d expected 7", stall_cnt);
        end
    endtask

    task automatic test_irq_during_div();
        logic [8:0] exp_seq [7];
        do_reset();
        exp_seq[0] = fl(S, S, S, R, 0);
        exp_seq[1] = fl(S, S, S, R, 0);
        exp_seq[2] = fl(S, S, S, R, 0);
        exp_seq[3] = fl(W, W, W, W, 0);
        exp_seq[4] = fl(S, R, R, W, 0);
        exp_seq[5] = fl(S, S, S, W, 0);
        exp_seq[6] = fl(W, R, R, W, 1);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, (i == 0), (i == 3), (i >= 1));
            checks++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL irq_in_div_seq_%0d: got %h expected %h", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        div_start = 1'b1;
        #1;
        checks++;
        if (obs !== fl(W, W, W, W, 0) || stall_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_div: got %h cnt %0d expected %h cnt 0",
                     obs, stall_cnt, fl(W, W, W, W, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        div_start = 1'b0;
        #1;
        checks++;
        if (obs !== fl(W, W, W, W, 0)) begin
            failures++;
            $display("[TB] FAIL reset_mid_div_run: got %h expected %h", obs, fl(W, W, W, W, 0));
        end
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (obs !== fl(S, S, S, R, 0)) begin
            failures++;
            $display("[TB] FAIL reset_mid_div_restart: got %h expected %h", obs, fl(S, S, S, R, 0));
        end
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (stall_cnt !== 32'd1) begin
            failures++;
            $display("[TB] FAIL reset_mid_div_stall_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        bit         irq_hold;
        do_reset();
        irq_hold = 0;
        for (int n = 0; n < 500; n++) begin
            // Requests are held until acknowledged, as the core does.
            if (!irq_hold) irq_hold = ($urandom_range(0, 15) == 0);
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), irq_hold);
            e = model_expect();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("[TB] FAIL random_flows_%0d: got %h expected %h", n, obs, e);
            end
            checks++;
            if (stall_cnt !== m_stalls) begin
                failures++;
                $display("[TB] FAIL random_stall_cnt_%0d: got %0d expected %0d", n, stall_cnt, m_stalls);
            end
            if (e[0]) irq_hold = 0;
            model_advance(e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jump_over_load_use();
        test_divide();
        test_irq();
        test_irq_during_div();
        test_reset_mid_div();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flow_ctrl.md
# flow_ctrl

Central pipeline flow controller for the rooth core. It produces the per-stage flow code for the PC register and every inter-stage register (IF/DE, DE/EX, EX/MEM): work, stop, or refresh. It resolves load-use, branch/jump, memory-stall, multi-cycle divide and interrupt-entry events by fixed priority, and sequences the multi-cycle divide-wait and interrupt-drain episodes with an internal state machine.

## Interface
- DRAIN_CYCLES, 2: cycles EX/MEM keep retiring before interrupt entry (1..15)
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- load_use_i  in  1  DE instruction sources rd of a load currently in EX
- jump_i  in  1  EX resolved a taken branch/jump; PC mux already selects the target
- mem_stall_i  in  1  data memory not ready; requesters hold their inputs while asserted
- div_start_i  in  1  EX holds a divide that needs the multi-cycle divider
- div_done_i  in  1  divider result valid this cycle
- irq_i  in  1  level interrupt request
- flow_pc_o, flow_de_o, flow_ex_o, flow_mem_o  out  `FLOW_WIDTH each  flow codes for PC, IF/DE, DE/EX, EX/MEM
- irq_ack_o  out  1  one-cycle pulse: PC loads the trap vector this cycle
- stall_cnt_o  out  32  saturating count of cycles with flow_pc_o = STOP

## Operation
- Flow encodings `FLOW_WORK/`FLOW_STOP/`FLOW_REFRESH come from rooth_defines.v. Flow outputs are combinational from state and inputs. State, drain counter, irq_pend and stall_cnt_o are registered.
- States: RUN, DIV_WAIT, IRQ_DRAIN.
- RUN, decided by priority (highest first):
  1. irq_i or irq_pend: go to IRQ_DRAIN and load cnt = DRAIN_CYCLES-1. Outputs: pc STOP, de REFRESH, ex REFRESH, mem WORK.
  2. mem_stall_i: all four outputs STOP.
  3. jump_i: pc WORK, de REFRESH, ex REFRESH, mem WORK.
  4. div_start_i: go to DIV_WAIT. Outputs: pc/de/ex STOP, mem REFRESH.
  5. load_use_i: pc STOP, de STOP, ex REFRESH, mem WORK.
  6. Otherwise all WORK.
- DIV_WAIT:
  - div_done_i=0: pc/de/ex STOP, mem REFRESH (bubble into MEM).
  - div_done_i=1: all WORK, return to RUN.
  - irq_i seen here sets irq_pend; the interrupt is taken on the first RUN cycle.
  - mem_stall_i is ignored because MEM holds a bubble.
- IRQ_DRAIN:
  - pc/de/ex STOP, mem WORK. cnt decrements each cycle.
  - At cnt=0: irq_ack_o=1, pc WORK (vector load), de/ex REFRESH, mem WORK, clear irq_pend, return to RUN.
  - mem_stall_i during drain: all STOP and cnt holds.
- stall_cnt_o increments by 1 per cycle with flow_pc_o=STOP and saturates at 32'hFFFF_FFFF.
- Reset:
  - state RUN, cnt 0, irq_pend 0, stall_cnt_o 0.
  - While rst_n low, all flow outputs WORK and irq_ack_o 0.
  - Reset mid-DIV_WAIT or mid-IRQ_DRAIN abandons the episode immediately.

## Timing
- Load-use: exactly one bubble. load_use_i drops the next cycle once the load leaves EX.
- Jump: flush takes effect on the next edge, so the two younger instructions are lost (jump penalty 2).
- Divide: entry is the cycle after div_start_i. The earliest div_done_i is one cycle after entry. The release cycle is WORK in the same cycle as div_done_i.
- Interrupt: irq_ack_o fires DRAIN_CYCLES cycles after the cycle irq_i is sampled in RUN, plus any mem-stall cycles. irq_i must stay high until irq_ack_o. irq_ack_o is never asserted two cycles in a row.
- Simultaneous jump_i and load_use_i: the jump wins; the flushed DE instruction makes the load-use moot.

## Structure
- Flow encodings and FLOW_WIDTH stay in rooth_defines.v.
- Add FC_RUN/FC_DIV_WAIT/FC_IRQ_DRAIN state encodings to the same header.
- Single flat module, no sub-module; the saturating counter is inline.

## Test plan
- load_use_i=1 for one cycle in RUN -> that cycle pc STOP, de STOP, ex REFRESH, mem WORK; next cycle all WORK; stall_cnt_o=1.
- jump_i=1 together with load_use_i=1 -> pc WORK, de REFRESH, ex REFRESH, mem WORK; stall_cnt_o unchanged.
- div_start_i pulse, div_done_i 5 cycles later -> 5 cycles pc/de/ex STOP with mem REFRESH, then all WORK; stall_cnt_o=5.
- irq_i held, DRAIN_CYCLES=2, no stalls -> irq_ack_o pulses exactly 2 cycles after sampling, with de/ex REFRESH in the ack cycle; mem_stall_i for 3 cycles mid-drain delays the ack by 3.
- irq_i raised during DIV_WAIT -> no ack until div_done_i; the IRQ_DRAIN sequence starts the cycle after release.
- rst_n low mid-DIV_WAIT -> all outputs WORK, stall_cnt_o=0; after release, state is RUN and the next div_start_i behaves normally.
